// File: rtl/ula_seq_if.sv
// ula_seq_if: instruction-issue handshake between a requester and ula_seq.
// The in_use_imm field exists only when ULA_SEQ_IMM_EN is defined.
interface ula_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_load;
  logic [2:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs;
  logic [3:0] in_data;
`ifdef ULA_SEQ_IMM_EN
  logic       in_use_imm;
`endif

  modport master (
    output in_valid, in_load, in_op, in_rd, in_rs, in_data,
`ifdef ULA_SEQ_IMM_EN
    output in_use_imm,
`endif
    input  in_ready
  );

  modport slave (
    input  in_valid, in_load, in_op, in_rd, in_rs, in_data,
`ifdef ULA_SEQ_IMM_EN
    input  in_use_imm,
`endif
    output in_ready
  );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: three-state instruction sequencer around an external 4-bit ALU.
// Owns a 4x4 register file; each accepted instruction takes IDLE->EXEC->DONE.
// Optional feature macro: ULA_SEQ_IMM_EN (immediate operand B from in_data).
module ula_seq (
  input  logic              clk,
  input  logic              rst,
  ula_seq_if.slave          bus,
  output logic signed [3:0] ula_a,
  output logic signed [3:0] ula_b,
  output logic [2:0]        ula_tula,
  input  logic [3:0]        ula_outp,
  input  logic              ula_stat,
  output logic              stat_q,
  output logic              done,
  input  logic [1:0]        obs_addr,
  output logic [3:0]        obs_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] rf_r [4];
  logic       in_ready_r;
  logic       load_r;
  logic [2:0] op_r;
  logic [1:0] rd_r;
  logic [1:0] rs_r;
  logic [3:0] data_r;
`ifdef ULA_SEQ_IMM_EN
  logic       use_imm_r;
`endif
  logic       stat_op_s;
  logic [3:0] opb_s;

  assign bus.in_ready = in_ready_r;

  // Read port is purely combinational; a commit becomes visible after its edge.
  assign obs_data = rf_r[obs_addr];

  // Compare opcodes update stat_q only; all other opcodes write R[rd].
  always_comb begin
    stat_op_s = 1'b0;
    case (op_r)
      3'b011, 3'b100, 3'b101: stat_op_s = 1'b1;
      default:                stat_op_s = 1'b0;
    endcase
  end

  // Operand B source at acceptance: immediate or R[rs]. No register write
  // can land between acceptance and EXEC, so sampling here equals EXEC reads.
  always_comb begin
    opb_s = rf_r[bus.in_rs];
`ifdef ULA_SEQ_IMM_EN
    if (bus.in_use_imm) begin
      opb_s = bus.in_data;
    end else begin
      opb_s = rf_r[bus.in_rs];
    end
`endif
  end

  // Sequencer FSM: latch on acceptance, commit at end of EXEC, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      for (int i = 0; i < 4; i++) rf_r[i] <= 4'd0;
      stat_q     <= 1'b0;
      done       <= 1'b0;
      in_ready_r <= 1'b1;
      ula_a      <= 4'sd0;
      ula_b      <= 4'sd0;
      ula_tula   <= 3'b000;
      load_r     <= 1'b0;
      op_r       <= 3'b000;
      rd_r       <= 2'd0;
      rs_r       <= 2'd0;
      data_r     <= 4'd0;
`ifdef ULA_SEQ_IMM_EN
      use_imm_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (bus.in_valid) begin
            load_r     <= bus.in_load;
            op_r       <= bus.in_op;
            rd_r       <= bus.in_rd;
            rs_r       <= bus.in_rs;
            data_r     <= bus.in_data;
`ifdef ULA_SEQ_IMM_EN
            use_imm_r  <= bus.in_use_imm;
`endif
            ula_a      <= $signed(rf_r[bus.in_rd]);
            ula_b      <= $signed(opb_s);
            ula_tula   <= bus.in_op;
            in_ready_r <= 1'b0;
            state_r    <= EXEC;
          end
        end
        EXEC: begin
          if (load_r) begin
            rf_r[rd_r] <= data_r;
          end else if (stat_op_s) begin
            stat_q <= ula_stat;
          end else begin
            rf_r[rd_r] <= ula_outp;
          end
          done    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done       <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          done       <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed self-checking bench for ula_seq with a behavioural ALU.
// ALU model: 000 a+b, 001 a-b, 010 -b, 011 eq, 100 gt, 101 lt (signed),
// 110 a&b, 111 a^b.
module tb_ula_seq;
  logic              clk;
  logic              rst;
  logic signed [3:0] ula_a, ula_b;
  logic [2:0]        ula_tula;
  logic [3:0]        ula_outp;
  logic              ula_stat;
  logic              stat_q;
  logic              done;
  logic [1:0]        obs_addr;
  logic [3:0]        obs_data;
  int                n_tests;
  int                n_fail;

  ula_seq_if bus ();

  ula_seq dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ula_a    (ula_a),
    .ula_b    (ula_b),
    .ula_tula (ula_tula),
    .ula_outp (ula_outp),
    .ula_stat (ula_stat),
    .stat_q   (stat_q),
    .done     (done),
    .obs_addr (obs_addr),
    .obs_data (obs_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural downstream ALU.
  always_comb begin
    ula_outp = 4'd0;
    ula_stat = 1'b0;
    case (ula_tula)
      3'b000: ula_outp = ula_a + ula_b;
      3'b001: ula_outp = ula_a - ula_b;
      3'b010: ula_outp = 4'd0 - ula_b;
      3'b011: ula_stat = (ula_a == ula_b);
      3'b100: ula_stat = (ula_a > ula_b);
      3'b101: ula_stat = (ula_a < ula_b);
      3'b110: ula_outp = ula_a & ula_b;
      3'b111: ula_outp = ula_a ^ ula_b;
      default: ula_outp = 4'd0;
    endcase
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic obs_read(input logic [1:0] a, output logic [3:0] d);
    obs_addr = a;
    #1;
    d = obs_data;
  endtask

  // Issue one instruction; lat = negedges from acceptance edge until done seen.
  task automatic run_instr(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs, input logic [3:0] data,
                           input logic imm, output int lat);
    for (int k = 0; k < 10 && bus.in_ready !== 1'b1; k++) @(negedge clk);
    bus.in_load = ld;
    bus.in_op   = op;
    bus.in_rd   = rd;
    bus.in_rs   = rs;
    bus.in_data = data;
`ifdef ULA_SEQ_IMM_EN
    bus.in_use_imm = imm;
`else
    if (imm) bus.in_data = data;
`endif
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.in_valid = 1'b0;
    end while (done !== 1'b1 && lat < 10);
  endtask

  task automatic test_reset();
    int lat;
    logic [3:0] d;
    do_reset();
    run_instr(1'b1, 3'b000, 2'd1, 2'd0, 4'h9, 1'b0, lat);
    run_instr(1'b0, 3'b101, 2'd1, 2'd0, 4'h0, 1'b0, lat);
    run_instr(1'b0, 3'b000, 2'd1, 2'd1, 4'h0, 1'b0, lat);
    do_reset();
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (stat_q !== 1'b0) begin n_fail++; $display("FAIL reset_stat: got %b expected 0", stat_q); end
    n_tests++; if (ula_a !== 4'sd0 || ula_b !== 4'sd0 || ula_tula !== 3'b000) begin
      n_fail++; $display("FAIL reset_ula: got a=%h b=%h op=%b expected 0 0 000", ula_a, ula_b, ula_tula); end
    for (int i = 0; i < 4; i++) begin
      obs_read(i[1:0], d);
      n_tests++; if (d !== 4'd0) begin n_fail++; $display("FAIL reset_R%0d: got %h expected 0", i, d); end
    end
  endtask

  task automatic test_add();
    int lat;
    logic [3:0] d;
    do_reset();
    run_instr(1'b1, 3'b000, 2'd0, 2'd0, 4'd3, 1'b0, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL load_latency: got %0d expected 2", lat); end
    run_instr(1'b1, 3'b000, 2'd1, 2'd0, 4'd2, 1'b0, lat);
    run_instr(1'b0, 3'b000, 2'd0, 2'd1, 4'd0, 1'b0, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
    obs_read(2'd0, d);
    n_tests++; if (d !== 4'd5) begin n_fail++; $display("FAIL add_R0: got %h expected 5", d); end
    n_tests++; if (stat_q !== 1'b0) begin n_fail++; $display("FAIL add_stat: got %b expected 0", stat_q); end
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (ula_a !== 4'sd3 || ula_b !== 4'sd2 || ula_tula !== 3'b000) begin
      n_fail++; $display("FAIL ula_hold: got a=%h b=%h op=%b expected 3 2 000", ula_a, ula_b, ula_tula); end
  endtask

  task automatic test_sub();
    int lat;
    logic [3:0] d;
    do_reset();
    run_instr(1'b1, 3'b000, 2'd0, 2'd0, 4'd3, 1'b0, lat);
    run_instr(1'b1, 3'b000, 2'd1, 2'd0, 4'd5, 1'b0, lat);
    run_instr(1'b0, 3'b001, 2'd0, 2'd1, 4'd0, 1'b0, lat);
    obs_read(2'd0, d);
    n_tests++; if (d !== 4'b1110) begin n_fail++; $display("FAIL sub_R0: got %b expected 1110", d); end
    run_instr(1'b0, 3'b010, 2'd2, 2'd1, 4'd0, 1'b0, lat);
    obs_read(2'd2, d);
    n_tests++; if (d !== 4'b1011) begin n_fail++; $display("FAIL neg_R2: got %b expected 1011", d); end
  endtask

  task automatic test_compare();
    int lat;
    logic [3:0] d;
    do_reset();
    run_instr(1'b1, 3'b000, 2'd0, 2'd0, 4'd3, 1'b0, lat);
    run_instr(1'b1, 3'b000, 2'd1, 2'd0, 4'd2, 1'b0, lat);
    run_instr(1'b0, 3'b100, 2'd0, 2'd1, 4'd0, 1'b0, lat);
    n_tests++; if (stat_q !== 1'b1) begin n_fail++; $display("FAIL gt_stat: got %b expected 1", stat_q); end
    obs_read(2'd0, d);
    n_tests++; if (d !== 4'd3) begin n_fail++; $display("FAIL gt_R0: got %h expected 3", d); end
    run_instr(1'b0, 3'b110, 2'd2, 2'd0, 4'd0, 1'b0, lat);
    n_tests++; if (stat_q !== 1'b1) begin n_fail++; $display("FAIL and_keeps_stat: got %b expected 1", stat_q); end
    run_instr(1'b0, 3'b011, 2'd0, 2'd1, 4'd0, 1'b0, lat);
    n_tests++; if (stat_q !== 1'b0) begin n_fail++; $display("FAIL eq_stat: got %b expected 0", stat_q); end
  endtask

  task automatic test_same_reg();
    int lat;
    logic [3:0] d;
    do_reset();
    run_instr(1'b1, 3'b000, 2'd3, 2'd0, 4'hC, 1'b0, lat);
    run_instr(1'b0, 3'b000, 2'd3, 2'd3, 4'd0, 1'b0, lat);
    obs_read(2'd3, d);
    n_tests++; if (d !== 4'h8) begin n_fail++; $display("FAIL same_reg_wrap: got %h expected 8", d); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    do_reset();
    obs_addr     = 2'd1;
    bus.in_load  = 1'b1;
    bus.in_op    = 3'b000;
    bus.in_rd    = 2'd1;
    bus.in_rs    = 2'd0;
    bus.in_data  = 4'd7;
`ifdef ULA_SEQ_IMM_EN
    bus.in_use_imm = 1'b0;
`endif
    bus.in_valid = 1'b1;
    @(negedge clk);  // T+1
    n_tests++; if (bus.in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_exec: got ready=%b done=%b expected 0 0", bus.in_ready, done); end
    n_tests++; if (obs_data !== 4'd0) begin n_fail++; $display("FAIL b2b_commit_old: got %h expected 0", obs_data); end
    bus.in_rd   = 2'd2;
    bus.in_data = 4'd6;
    @(negedge clk);  // T+2
    n_tests++; if (bus.in_ready !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: got ready=%b done=%b expected 0 1", bus.in_ready, done); end
    n_tests++; if (obs_data !== 4'd7) begin n_fail++; $display("FAIL b2b_R1: got %h expected 7", obs_data); end
    obs_addr = 2'd2;
    @(negedge clk);  // T+3
    n_tests++; if (bus.in_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got ready=%b done=%b expected 1 0", bus.in_ready, done); end
    n_tests++; if (obs_data !== 4'd0) begin n_fail++; $display("FAIL b2b_no_queue: got %h expected 0", obs_data); end
    @(negedge clk);  // T+4
    bus.in_valid = 1'b0;
    n_tests++; if (bus.in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_exec2: got ready=%b done=%b expected 0 0", bus.in_ready, done); end
    @(negedge clk);  // T+5
    n_tests++; if (done !== 1'b1 || obs_data !== 4'd6) begin
      n_fail++; $display("FAIL b2b_second: got done=%b R2=%h expected 1 6", done, obs_data); end
    obs_read(2'd1, d);
    n_tests++; if (d !== 4'd7) begin n_fail++; $display("FAIL b2b_R1_kept: got %h expected 7", d); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [3:0] d;
    logic saw_done;
    do_reset();
    run_instr(1'b1, 3'b000, 2'd0, 2'd0, 4'd3, 1'b0, lat);
    run_instr(1'b1, 3'b000, 2'd1, 2'd0, 4'd2, 1'b0, lat);
    @(negedge clk);
    bus.in_load  = 1'b0;
    bus.in_op    = 3'b000;
    bus.in_rd    = 2'd0;
    bus.in_rs    = 2'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);  // EXEC
    bus.in_valid = 1'b0;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_exec: got ready=%b expected 0", bus.in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (bus.in_ready !== 1'b1 || done !== 1'b0 || stat_q !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: got ready=%b done=%b stat=%b expected 1 0 0", bus.in_ready, done, stat_q); end
    for (int i = 0; i < 4; i++) begin
      obs_read(i[1:0], d);
      n_tests++; if (d !== 4'd0) begin n_fail++; $display("FAIL mid_R%0d: got %h expected 0", i, d); end
    end
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %b expected 0", saw_done); end
  endtask

`ifdef ULA_SEQ_IMM_EN
  task automatic test_imm();
    int lat;
    logic [3:0] d;
    do_reset();
    run_instr(1'b1, 3'b000, 2'd2, 2'd0, 4'b0101, 1'b0, lat);
    run_instr(1'b0, 3'b111, 2'd2, 2'd0, 4'b0011, 1'b1, lat);
    obs_read(2'd2, d);
    n_tests++; if (d !== 4'b0110) begin n_fail++; $display("FAIL imm_R2: got %b expected 0110", d); end
  endtask
`endif

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    obs_addr     = 2'd0;
    bus.in_valid = 1'b0;
    bus.in_load  = 1'b0;
    bus.in_op    = 3'b000;
    bus.in_rd    = 2'd0;
    bus.in_rs    = 2'd0;
    bus.in_data  = 4'd0;
`ifdef ULA_SEQ_IMM_EN
    bus.in_use_imm = 1'b0;
`endif
    test_reset();
    test_add();
    test_sub();
    test_compare();
    test_same_reg();
    test_back_to_back();
    test_reset_mid();
`ifdef ULA_SEQ_IMM_EN
    test_imm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
